// File: rtl/carry_resolve.sv
// carry_resolve: iterative carry resolution of half-adder propagate/generate
// vectors into a full N-bit sum with cout/ovf/zero/neg flags. One carry step
// per clock; valid/ready handshake on input and output.
module carry_resolve #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  add_rd,
    input  logic [N-1:0]  co,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          cout,
    output logic          ovf,
    output logic          zero,
    output logic          neg,
    output logic [CW-1:0] iter_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [N-1:0]  r_s;
    logic [N-1:0]  r_c;
    logic          r_cout;
    logic          r_pmsb;
    logic          r_gmsb;
    logic [CW-1:0] r_iter;
    logic          r_ovf;
    logic          r_zero;
    logic          r_neg;

    logic [N-1:0]  w_s_nxt;
    logic [N-1:0]  w_c_nxt;
    logic [N-1:0]  w_t;
    logic          w_cout_nxt;
    logic          w_pmsb_nxt;
    logic          w_gmsb_nxt;
    logic [CW-1:0] w_iter_nxt;
    logic          w_fin;
    logic          w_ovf_nxt;
    logic          w_zero_nxt;
    logic          w_neg_nxt;

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_c     <= '0;
            r_cout  <= 1'b0;
            r_pmsb  <= 1'b0;
            r_gmsb  <= 1'b0;
            r_iter  <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_c     <= w_c_nxt;
            r_cout  <= w_cout_nxt;
            r_pmsb  <= w_pmsb_nxt;
            r_gmsb  <= w_gmsb_nxt;
            r_iter  <= w_iter_nxt;
            r_ovf   <= w_ovf_nxt;
            r_zero  <= w_zero_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    // Next-state and datapath: accept, one carry step per cycle, hold in DONE
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_c_nxt     = r_c;
        w_cout_nxt  = r_cout;
        w_pmsb_nxt  = r_pmsb;
        w_gmsb_nxt  = r_gmsb;
        w_iter_nxt  = r_iter;
        w_t         = '0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_s_nxt     = add_rd;
                    w_c_nxt     = {co[N-2:0], 1'b0};
                    w_cout_nxt  = co[N-1];
                    w_pmsb_nxt  = add_rd[N-1];
                    w_gmsb_nxt  = co[N-1];
                    w_iter_nxt  = '0;
                    w_state_nxt = (w_c_nxt == '0) ? ST_DONE : ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_t         = r_s & r_c;
                w_s_nxt     = r_s ^ r_c;
                w_cout_nxt  = r_cout | w_t[N-1];
                w_c_nxt     = {w_t[N-2:0], 1'b0};
                w_iter_nxt  = r_iter + CW'(1);
                w_state_nxt = (w_c_nxt == '0) ? ST_DONE : ST_RESOLVE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Flags are captured from the final sum on the edge that enters DONE
        w_fin      = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
        w_zero_nxt = w_fin ? (w_s_nxt == '0) : r_zero;
        w_neg_nxt  = w_fin ? w_s_nxt[N-1] : r_neg;
        // Equal operand signs (pmsb=0) share sign gmsb; overflow if sum sign differs
        w_ovf_nxt  = w_fin ? (~w_pmsb_nxt & (w_s_nxt[N-1] ^ w_gmsb_nxt)) : r_ovf;
    end

    // Output mapping: handshake decoded from state, results from registers
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        sum       = r_s;
        cout      = r_cout;
        ovf       = r_ovf;
        zero      = r_zero;
        neg       = r_neg;
        iter_cnt  = r_iter;
    end

endmodule

// File: tb/tb_carry_resolve.sv
// Self-checking bench for carry_resolve: directed table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_carry_resolve;

    localparam int unsigned N  = 16;
    localparam int unsigned CW = $clog2(N) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  add_rd;
    logic [N-1:0]  co;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic          neg;
    logic [CW-1:0] iter_cnt;

    int n_cmp = 0;
    int n_err = 0;

    carry_resolve #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_rd    (add_rd),
        .co        (co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .iter_cnt  (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic [N-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        logic         e_zero;
        logic         e_neg;
        int           e_iter;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Iterations = longest carry travel: a carry generated at bit i moves
    // through consecutive propagate bits, one bit position per step, until it
    // is absorbed by a non-propagate bit or leaves the word.
    function automatic int chain_len(input logic [N-1:0] p, input logic [N-1:0] g);
        int best;
        best = 0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (g[i]) begin
                int m;
                m = 0;
                for (int j = i + 1; j < int'(N); j++) begin
                    m++;
                    if (!p[j]) break;
                end
                if (m > best) best = m;
            end
        end
        return best;
    endfunction

    // Issue one operation, wait for out_valid, check results and latency.
    // Returns at the negedge where out_valid is first seen high.
    task automatic run_op(input string tag, input logic [N-1:0] p, input logic [N-1:0] g,
                          input logic [N-1:0] e_sum, input logic e_cout, input logic e_ovf,
                          input logic e_zero, input logic e_neg, input int e_iter);
        int edges;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        add_rd   = p;
        co       = g;
        edges    = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                in_valid = 1'b0;
                add_rd   = N'($urandom);
                co       = N'($urandom);
            end
            if (out_valid) break;
            if (edges > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s.timeout: no out_valid after %0d edges", tag, edges);
                return;
            end
        end
        check({tag, ".latency"}, 32'(edges), 32'(e_iter + 1));
        check({tag, ".sum"},     32'(sum),   32'(e_sum));
        check({tag, ".cout"},    32'(cout),  32'(e_cout));
        check({tag, ".ovf"},     32'(ovf),   32'(e_ovf));
        check({tag, ".zero"},    32'(zero),  32'(e_zero));
        check({tag, ".neg"},     32'(neg),   32'(e_neg));
        check({tag, ".iter"},    32'(iter_cnt), 32'(e_iter));
        check({tag, ".iter_bound"}, 32'(iter_cnt <= CW'(N - 1)), 32'd1);
    endtask

    initial begin
        logic [N-1:0] a, b, rs;
        logic [N:0]   full;
        logic         rovf;

        tbl[0] = '{"one_plus_one", 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{"full_ripple",  16'hFFFE, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 15};
        tbl[2] = '{"no_carry",     16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{"neg_ovf",      16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[4] = '{"pos_ovf",      16'h7FFE, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 15};

        // Reset held with in_valid asserted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        add_rd    = 16'hFFFE;
        co        = 16'h0001;
        repeat (3) @(negedge clk);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sum",       32'(sum),       32'd0);
        check("rst.cout",      32'(cout),      32'd0);
        check("rst.ovf",       32'(ovf),       32'd0);
        check("rst.zero",      32'(zero),      32'd0);
        check("rst.neg",       32'(neg),       32'd0);
        check("rst.iter",      32'(iter_cnt),  32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].name, tbl[i].p, tbl[i].g, tbl[i].e_sum, tbl[i].e_cout,
                   tbl[i].e_ovf, tbl[i].e_zero, tbl[i].e_neg, tbl[i].e_iter);
            @(negedge clk);
        end

        // Backpressure: outputs hold, in_valid ignored while DONE
        out_ready = 1'b0;
        run_op("bp", 16'h0006, 16'h0001, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            add_rd   = N'($urandom);
            co       = 16'h0000;
            @(negedge clk);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_ready", 32'(in_ready),  32'd0);
            check("bp.hold_sum",   32'(sum),       32'h0008);
            check("bp.hold_iter",  32'(iter_cnt),  32'd3);
            check("bp.hold_flags", 32'({cout, ovf, zero, neg}), 32'd0);
        end
        // Handoff edge must not accept even with in_valid high
        add_rd    = 16'h1234;
        co        = 16'h0000;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.handoff_in_ready",  32'(in_ready),  32'd1);
        check("bp.handoff_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        run_op("after_bp", 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);

        // Reset during RESOLVE at iteration 5
        in_valid = 1'b1;
        add_rd   = 16'hFFFE;
        co       = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("midrst.busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.sum",       32'(sum),       32'd0);
        check("midrst.iter",      32'(iter_cnt),  32'd0);
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        run_op("pre_rst", 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("donerst.out_valid", 32'(out_valid), 32'd0);
        check("donerst.sum",       32'(sum),       32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        run_op("post_rst", 16'h0000, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);

        // Randomized operands against the arithmetic reference model
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            if (i % 3 == 0) b = ~a + N'($urandom_range(0, 2));
            else            b = N'($urandom);
            full = {1'b0, a} + {1'b0, b};
            rs   = full[N-1:0];
            rovf = (a[N-1] == b[N-1]) && (rs[N-1] != a[N-1]);
            run_op($sformatf("rnd%0d", i), a ^ b, a & b, rs, full[N], rovf,
                   (rs == '0), rs[N-1], chain_len(a ^ b, a & b));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
